// File: rtl/datapath_pkg.sv
// Shared ALU op encodings and ID/EX control type for the datapath_pipe slice.
package datapath_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ULA_ADD = 3'b000,
        ULA_SUB = 3'b001,
        ULA_AND = 3'b010,
        ULA_OR  = 3'b011,
        ULA_XOR = 3'b100,
        ULA_SLT = 3'b101,
        ULA_SHL = 3'b110,
        ULA_SHR = 3'b111
    } ula_op_t;

    // Control half of the ID/EX register; data fields depend on the top's widths
    // and are kept beside it in datapath_pipe.
    typedef struct packed {
        logic    valid;
        ula_op_t op;
        logic    wb_en;
    } idex_ctrl_t;

endpackage

// File: rtl/datapath_regfile.sv
// Register file: NumRegs x DataWidth, two asynchronous reads, two synchronous
// writes (pipeline write-back and external load), synchronous active-high reset.
module datapath_regfile #(
    parameter int DataWidth = 8,
    parameter int NumRegs   = 8,
    localparam int RegAddrW = $clog2(NumRegs)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [RegAddrW-1:0]  ra1,
    input  logic [RegAddrW-1:0]  ra2,
    output logic [DataWidth-1:0] rd1,
    output logic [DataWidth-1:0] rd2,
    input  logic                 we_wb,
    input  logic [RegAddrW-1:0]  wa_wb,
    input  logic [DataWidth-1:0] wd_wb,
    input  logic                 we_ext,
    input  logic [RegAddrW-1:0]  wa_ext,
    input  logic [DataWidth-1:0] wd_ext
);

    logic [DataWidth-1:0] regs_q [NumRegs];
    logic [DataWidth-1:0] regs_d [NumRegs];

    // Next contents: external write first so a same-address write-back overrides it.
    always_comb begin
        regs_d = regs_q;
        if (we_ext) begin
            regs_d[wa_ext] = wd_ext;
        end
        if (we_wb) begin
            regs_d[wa_wb] = wd_wb;
        end
    end

    // Register storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1 = regs_q[ra1];
    assign rd2 = regs_q[ra2];

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage ALU datapath: RD (regfile read, forwarding, hazard stall) feeds
// ID/EX; EX runs the ALU and registers result/flags into the WB stage, which
// drives the outputs and writes back into the register file.
module datapath_pipe
    import datapath_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int NumRegs   = 8,
    localparam int RegAddrW = $clog2(NumRegs)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we3,
    input  logic [RegAddrW-1:0]  wa3,
    input  logic [DataWidth-1:0] wd3,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RegAddrW-1:0]  ra1,
    input  logic [RegAddrW-1:0]  ra2,
    input  logic                 select_src,
    input  logic [DataWidth-1:0] constante,
    input  logic [2:0]           ULAControl,
    input  logic                 wb_en,
    input  logic [RegAddrW-1:0]  wb_addr,
    output logic                 res_valid,
    output logic [DataWidth-1:0] ULAResult,
    output logic                 Flag_z,
    output logic                 CarryOut,
    output logic                 Overflow,
    output logic                 Negative
);

    localparam int ShiftW = $clog2(DataWidth);
    localparam int Msb    = DataWidth - 1;

    // Register file read data
    logic [DataWidth-1:0] rd1, rd2;

    // RD stage
    logic                 fwd_a, fwd_b, hazard, ready, accept;
    logic [DataWidth-1:0] src_a, src_b;

    // ID/EX stage
    idex_ctrl_t           idex_ctrl_q, idex_ctrl_d;
    logic [DataWidth-1:0] idex_a_q, idex_a_d;
    logic [DataWidth-1:0] idex_b_q, idex_b_d;
    logic [RegAddrW-1:0]  idex_wb_addr_q, idex_wb_addr_d;

    // ALU
    logic [DataWidth-1:0] alu_res;
    logic [DataWidth:0]   alu_wide;
    logic [ShiftW-1:0]    shamt;
    logic                 alu_c, alu_v;

    // WB stage
    logic                 res_valid_q, res_valid_d;
    logic                 wb_en_q, wb_en_d;
    logic [RegAddrW-1:0]  wb_addr_q, wb_addr_d;
    logic [DataWidth-1:0] result_q, result_d;
    logic                 flag_z_q, flag_z_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 neg_q, neg_d;

    datapath_regfile #(
        .DataWidth (DataWidth),
        .NumRegs   (NumRegs)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .we_wb  (wb_en_q),
        .wa_wb  (wb_addr_q),
        .wd_wb  (result_q),
        .we_ext (we3),
        .wa_ext (wa3),
        .wd_ext (wd3)
    );

    // Operand selection: the WB result is bypassed because its regfile write
    // lands only at the end of this cycle; the op in ID/EX cannot be bypassed
    // yet, so a dependency on it stalls RD for one cycle.
    always_comb begin
        fwd_a  = wb_en_q && (wb_addr_q == ra1);
        fwd_b  = wb_en_q && (wb_addr_q == ra2);
        src_a  = fwd_a ? result_q : rd1;
        src_b  = select_src ? constante : (fwd_b ? result_q : rd2);
        hazard = idex_ctrl_q.valid && idex_ctrl_q.wb_en &&
                 ((idex_wb_addr_q == ra1) ||
                  (!select_src && (idex_wb_addr_q == ra2)));
        ready  = !reset && !hazard;
        accept = in_valid && ready;
    end

    // ID/EX capture; a stalled or idle cycle turns into a bubble.
    always_comb begin
        idex_ctrl_d.valid = accept;
        idex_ctrl_d.op    = ula_op_t'(ULAControl);
        idex_ctrl_d.wb_en = wb_en;
        idex_a_d          = src_a;
        idex_b_d          = src_b;
        idex_wb_addr_d    = wb_addr;
    end

    // ALU: shifts widen by one bit so the bit pushed out becomes the carry.
    always_comb begin
        shamt    = idex_b_q[ShiftW-1:0];
        alu_wide = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (idex_ctrl_q.op)
            ULA_ADD: begin
                alu_wide = {1'b0, idex_a_q} + {1'b0, idex_b_q};
                alu_res  = alu_wide[Msb:0];
                alu_c    = alu_wide[DataWidth];
                alu_v    = (idex_a_q[Msb] == idex_b_q[Msb]) && (alu_res[Msb] != idex_a_q[Msb]);
            end
            ULA_SUB: begin
                alu_res = idex_a_q - idex_b_q;
                alu_c   = (idex_a_q >= idex_b_q);
                alu_v   = (idex_a_q[Msb] != idex_b_q[Msb]) && (alu_res[Msb] != idex_a_q[Msb]);
            end
            ULA_AND: alu_res = idex_a_q & idex_b_q;
            ULA_OR:  alu_res = idex_a_q | idex_b_q;
            ULA_XOR: alu_res = idex_a_q ^ idex_b_q;
            ULA_SLT: alu_res = {{(DataWidth-1){1'b0}}, ($signed(idex_a_q) < $signed(idex_b_q))};
            ULA_SHL: begin
                alu_wide = {1'b0, idex_a_q} << shamt;
                alu_res  = alu_wide[Msb:0];
                alu_c    = alu_wide[DataWidth];
            end
            ULA_SHR: begin
                alu_wide = {idex_a_q, 1'b0} >> shamt;
                alu_res  = alu_wide[DataWidth:1];
                alu_c    = alu_wide[0];
            end
            default: ;
        endcase
    end

    // WB stage: result and flags move only when an op completes, so the
    // outputs hold between res_valid pulses.
    always_comb begin
        res_valid_d = idex_ctrl_q.valid;
        wb_en_d     = idex_ctrl_q.valid && idex_ctrl_q.wb_en;
        wb_addr_d   = idex_wb_addr_q;
        result_d    = result_q;
        flag_z_d    = flag_z_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        neg_d       = neg_q;
        if (idex_ctrl_q.valid) begin
            result_d = alu_res;
            flag_z_d = (alu_res == '0);
            carry_d  = alu_c;
            ovf_d    = alu_v;
            neg_d    = alu_res[Msb];
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_ctrl_q    <= '0;
            idex_a_q       <= '0;
            idex_b_q       <= '0;
            idex_wb_addr_q <= '0;
            res_valid_q    <= 1'b0;
            wb_en_q        <= 1'b0;
            wb_addr_q      <= '0;
            result_q       <= '0;
            flag_z_q       <= 1'b0;
            carry_q        <= 1'b0;
            ovf_q          <= 1'b0;
            neg_q          <= 1'b0;
        end else begin
            idex_ctrl_q    <= idex_ctrl_d;
            idex_a_q       <= idex_a_d;
            idex_b_q       <= idex_b_d;
            idex_wb_addr_q <= idex_wb_addr_d;
            res_valid_q    <= res_valid_d;
            wb_en_q        <= wb_en_d;
            wb_addr_q      <= wb_addr_d;
            result_q       <= result_d;
            flag_z_q       <= flag_z_d;
            carry_q        <= carry_d;
            ovf_q          <= ovf_d;
            neg_q          <= neg_d;
        end
    end

    assign in_ready  = ready;
    assign res_valid = res_valid_q;
    assign ULAResult = result_q;
    assign Flag_z    = flag_z_q;
    assign CarryOut  = carry_q;
    assign Overflow  = ovf_q;
    assign Negative  = neg_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Testbench for datapath_pipe (DataWidth=8, NumRegs=8): directed scenarios
// plus randomized ops checked against an in-order architectural model.
module tb_datapath_pipe;

    localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3;
    localparam int OP_XOR = 4, OP_SLT = 5, OP_SHL = 6, OP_SHR = 7;

    typedef struct {
        logic [7:0] res;
        logic       z, c, v, n;
        int         cyc;
    } obs_t;

    logic       clk, reset, we3, in_valid, in_ready, select_src, wb_en;
    logic [2:0] wa3, ra1, ra2, wb_addr, ULAControl;
    logic [7:0] wd3, constante, ULAResult;
    logic       res_valid, Flag_z, CarryOut, Overflow, Negative;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    obs_t obs_q[$];

    datapath_pipe #(.DataWidth(8), .NumRegs(8)) dut (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .in_valid(in_valid), .in_ready(in_ready), .ra1(ra1), .ra2(ra2),
        .select_src(select_src), .constante(constante), .ULAControl(ULAControl),
        .wb_en(wb_en), .wb_addr(wb_addr), .res_valid(res_valid), .ULAResult(ULAResult),
        .Flag_z(Flag_z), .CarryOut(CarryOut), .Overflow(Overflow), .Negative(Negative)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp used to measure latency
    always @(posedge clk) cyc <= cyc + 1;

    // Collect every completed op, sampled mid-cycle
    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            obs_t o;
            o.res = ULAResult; o.z = Flag_z; o.c = CarryOut;
            o.v = Overflow; o.n = Negative; o.cyc = cyc;
            obs_q.push_back(o);
        end
    end

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required summary before it");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [11:0] pk(input obs_t o);
        return {o.res, o.z, o.c, o.v, o.n};
    endfunction

    // Architectural ALU computed with plain integer arithmetic
    function automatic obs_t alu_model(input int op, input int a, input int b);
        obs_t r;
        int s, sa, sb, amt;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        s = 0; r.c = 1'b0; r.v = 1'b0; r.cyc = 0;
        amt = b % 8;
        case (op)
            OP_ADD: begin s = a + b; r.c = (s > 255); r.v = ((sa + sb) > 127) || ((sa + sb) < -128); end
            OP_SUB: begin s = a - b; r.c = (a >= b);  r.v = ((sa - sb) > 127) || ((sa - sb) < -128); end
            OP_AND: s = a & b;
            OP_OR:  s = a | b;
            OP_XOR: s = a ^ b;
            OP_SLT: s = (sa < sb) ? 1 : 0;
            OP_SHL: begin s = a * (1 << amt); r.c = (amt != 0) && (((s / 256) % 2) == 1); end
            default: begin s = a / (1 << amt); r.c = (amt != 0) && (((a / (1 << (amt - 1))) % 2) == 1); end
        endcase
        r.res = 8'(s & 255);
        r.z = (r.res == 8'h00);
        r.n = r.res[7];
        return r;
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic load_reg(input int a, input int d);
        we3 = 1'b1; wa3 = 3'(a); wd3 = 8'(d);
        @(posedge clk); #1;
        we3 = 1'b0;
    endtask

    // Present one op and hold it until accepted (bounded); returns stall count
    task automatic issue(input int op, input int a1, input int a2, input bit sel, input int k,
                         input bit wen, input int wa, output int stalls, output int acc_cyc, output bit ok);
        ULAControl = 3'(op); ra1 = 3'(a1); ra2 = 3'(a2); select_src = sel;
        constante = 8'(k); wb_en = wen; wb_addr = 3'(wa); in_valid = 1'b1;
        stalls = 0; acc_cyc = -1; ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin ok = 1'b1; acc_cyc = cyc; end
            else stalls++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Fetch the next completed op (bounded wait)
    task automatic wait_result(output obs_t o, output bit ok);
        ok = 1'b0;
        o.res = 8'h00; o.z = 1'b0; o.c = 1'b0; o.v = 1'b0; o.n = 1'b0; o.cyc = -1;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (obs_q.size() > 0) begin o = obs_q.pop_front(); ok = 1'b1; end
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        int st, ac; bit ok, okr; obs_t o;
        reset = 1'b1;
        repeat (3) @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({res_valid, ULAResult, Flag_z, CarryOut, Overflow, Negative} !== 13'h0) begin
            n_fail++; $display("[TB] FAIL reset_outputs: got %h required 0", {res_valid, ULAResult, Flag_z, CarryOut, Overflow, Negative});
        end
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ready_after_reset: got %b required 1", in_ready); end
        @(posedge clk); #1;
        obs_q.delete();
        issue(OP_ADD, 1, 2, 1'b0, 0, 1'b0, 0, st, ac, ok);
        wait_result(o, okr);
        n_cmp++;
        if (!ok || !okr || pk(o) !== {8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("[TB] FAIL reset_read_add: got %h required %h", pk(o), {8'h00, 4'b1000});
        end
        n_cmp++;
        if (o.cyc - ac != 2) begin n_fail++; $display("[TB] FAIL latency: got %0d required 2", o.cyc - ac); end
    endtask

    task automatic test_load_add_sub();
        int st, ac; bit ok, okr; obs_t o;
        load_reg(1, 8'hF0);
        load_reg(2, 8'h20);
        issue(OP_ADD, 1, 2, 1'b0, 0, 1'b0, 0, st, ac, ok);
        wait_result(o, okr);
        n_cmp++;
        if (!ok || !okr || pk(o) !== {8'h10, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("[TB] FAIL add_f0_20: got %h required %h", pk(o), {8'h10, 4'b0100});
        end
        issue(OP_SUB, 2, 1, 1'b0, 0, 1'b0, 0, st, ac, ok);
        wait_result(o, okr);
        n_cmp++;
        if (!ok || !okr || pk(o) !== {8'h30, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("[TB] FAIL sub_20_f0: got %h required %h", pk(o), {8'h30, 4'b0000});
        end
        // External write in the same cycle as a read is not bypassed
        load_reg(6, 8'h11);
        we3 = 1'b1; wa3 = 3'd6; wd3 = 8'h99;
        issue(OP_ADD, 6, 0, 1'b1, 0, 1'b0, 0, st, ac, ok);
        we3 = 1'b0;
        wait_result(o, okr);
        n_cmp++;
        if (!ok || !okr || pk(o) !== {8'h11, 4'b0000}) begin
            n_fail++; $display("[TB] FAIL we3_no_bypass: got %h required %h", pk(o), {8'h11, 4'b0000});
        end
        issue(OP_ADD, 6, 0, 1'b1, 0, 1'b0, 0, st, ac, ok);
        wait_result(o, okr);
        n_cmp++;
        if (!ok || !okr || pk(o) !== {8'h99, 4'b0001}) begin
            n_fail++; $display("[TB] FAIL we3_visible_later: got %h required %h", pk(o), {8'h99, 4'b0001});
        end
    endtask

    task automatic test_back_to_back();
        int st1, ac1, st2, ac2; bit ok1, ok2, okr1, okr2; obs_t o1, o2;
        issue(OP_ADD, 1, 0, 1'b1, 1, 1'b1, 3, st1, ac1, ok1);
        issue(OP_ADD, 3, 3, 1'b0, 0, 1'b1, 4, st2, ac2, ok2);
        wait_result(o1, okr1);
        wait_result(o2, okr2);
        n_cmp++;
        if (!ok1 || !ok2 || st1 != 0 || st2 != 1) begin
            n_fail++; $display("[TB] FAIL hazard_stall: got stalls %0d/%0d required 0/1", st1, st2);
        end
        n_cmp++;
        if (!okr1 || !okr2 || {pk(o1), pk(o2)} !== {8'hF1, 4'b0001, 8'hE2, 4'b0101}) begin
            n_fail++; $display("[TB] FAIL hazard_results: got %h required %h", {pk(o1), pk(o2)}, {8'hF1, 4'b0001, 8'hE2, 4'b0101});
        end
        issue(OP_ADD, 4, 0, 1'b1, 0, 1'b0, 0, st1, ac1, ok1);
        wait_result(o1, okr1);
        n_cmp++;
        if (!ok1 || !okr1 || pk(o1) !== {8'hE2, 4'b0001}) begin
            n_fail++; $display("[TB] FAIL r4_readback: got %h required %h", pk(o1), {8'hE2, 4'b0001});
        end
        // Independent ops flow at one per cycle
        issue(OP_ADD, 1, 2, 1'b0, 0, 1'b0, 0, st1, ac1, ok1);
        issue(OP_SUB, 2, 1, 1'b0, 0, 1'b0, 0, st2, ac2, ok2);
        wait_result(o1, okr1);
        wait_result(o2, okr2);
        n_cmp++;
        if (!ok1 || !ok2 || !okr1 || !okr2 || st2 != 0 || o2.cyc - o1.cyc != 1 ||
            {pk(o1), pk(o2)} !== {8'h10, 4'b0100, 8'h30, 4'b0000}) begin
            n_fail++; $display("[TB] FAIL throughput: got stall %0d gap %0d res %h required 0 1 %h",
                               st2, o2.cyc - o1.cyc, {pk(o1), pk(o2)}, {8'h10, 4'b0100, 8'h30, 4'b0000});
        end
    endtask

    task automatic test_forward_wb();
        int st1, ac1, st2, ac2; bit ok1, ok2, okr1, okr2; obs_t o1, o2;
        issue(OP_ADD, 1, 0, 1'b1, 5, 1'b1, 5, st1, ac1, ok1);
        idle_cycles(1);
        we3 = 1'b1; wa3 = 3'd5; wd3 = 8'h55;
        issue(OP_ADD, 2, 5, 1'b0, 0, 1'b0, 0, st2, ac2, ok2);
        we3 = 1'b0;
        wait_result(o1, okr1);
        wait_result(o2, okr2);
        n_cmp++;
        if (!ok1 || !ok2 || st2 != 0 || ac2 - ac1 != 2) begin
            n_fail++; $display("[TB] FAIL forward_no_stall: got stall %0d gap %0d required 0 2", st2, ac2 - ac1);
        end
        n_cmp++;
        if (!okr1 || !okr2 || {pk(o1), pk(o2)} !== {8'hF5, 4'b0001, 8'h15, 4'b0100}) begin
            n_fail++; $display("[TB] FAIL forward_value: got %h required %h", {pk(o1), pk(o2)}, {8'hF5, 4'b0001, 8'h15, 4'b0100});
        end
        issue(OP_ADD, 5, 0, 1'b1, 0, 1'b0, 0, st1, ac1, ok1);
        wait_result(o1, okr1);
        n_cmp++;
        if (!ok1 || !okr1 || pk(o1) !== {8'hF5, 4'b0001}) begin
            n_fail++; $display("[TB] FAIL wb_beats_we3: got %h required %h", pk(o1), {8'hF5, 4'b0001});
        end
    endtask

    task automatic test_flags();
        int st, ac; bit ok, okr; obs_t o;
        int          ops[7]  = '{OP_ADD, OP_SHL, OP_SLT, OP_SHR, OP_SUB, OP_SHL, OP_SHL};
        int          srcs[7] = '{1, 2, 3, 2, 1, 2, 2};
        int          ks[7]   = '{1, 1, 1, 1, 0, 0, 9};
        bit          sels[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [11:0] exp[7]  = '{{8'h80, 4'b0011}, {8'h02, 4'b0100}, {8'h01, 4'b0000},
                                 {8'h40, 4'b0100}, {8'h00, 4'b1100}, {8'h81, 4'b0001},
                                 {8'h02, 4'b0100}};
        load_reg(1, 8'h7F);
        load_reg(2, 8'h81);
        load_reg(3, 8'h80);
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], srcs[i], srcs[i], sels[i], ks[i], 1'b0, 0, st, ac, ok);
            wait_result(o, okr);
            n_cmp++;
            if (!ok || !okr || pk(o) !== exp[i]) begin
                n_fail++; $display("[TB] FAIL flags_case%0d: got %h required %h", i, pk(o), exp[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int st, ac; bit ok, okr; obs_t o;
        issue(OP_ADD, 1, 0, 1'b1, 1, 1'b1, 6, st, ac, ok);
        issue(OP_XOR, 2, 3, 1'b0, 0, 1'b1, 7, st, ac, ok);
        reset = 1'b1;
        @(posedge clk); #1;
        obs_q.delete();
        @(negedge clk);
        n_cmp++;
        if ({res_valid, ULAResult, Flag_z, CarryOut, Overflow, Negative} !== 13'h0) begin
            n_fail++; $display("[TB] FAIL midflight_reset_outputs: got %h required 0", {res_valid, ULAResult, Flag_z, CarryOut, Overflow, Negative});
        end
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midflight_ready: got %b required 1", in_ready); end
        @(posedge clk); #1;
        idle_cycles(3);
        n_cmp++;
        if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL midflight_no_result: got %0d results required 0", obs_q.size()); end
        obs_q.delete();
        for (int r = 0; r < 8; r++) begin
            issue(OP_ADD, r, 0, 1'b1, 0, 1'b0, 0, st, ac, ok);
            wait_result(o, okr);
            n_cmp++;
            if (!ok || !okr || pk(o) !== {8'h00, 4'b1000}) begin
                n_fail++; $display("[TB] FAIL cleared_r%0d: got %h required %h", r, pk(o), {8'h00, 4'b1000});
            end
        end
    endtask

    task automatic test_random();
        int mdl[8];
        obs_t exp_q[$];
        obs_t e, m;
        logic [11:0] last_exp = {8'h00, 4'b1000};
        bit prev_acc = 1'b0, prev_wen = 1'b0, exp_ready, acc;
        int prev_wa = 0;
        int op, a1, a2, k, wa, st, ac; bit sel, wen, ok, okr; obs_t o;
        for (int i = 0; i < 8; i++) begin
            mdl[i] = $urandom_range(0, 255);
            load_reg(i, mdl[i]);
        end
        for (int i = 0; i < 403; i++) begin
            op = $urandom_range(0, 7); a1 = $urandom_range(0, 7); a2 = $urandom_range(0, 7);
            sel = ($urandom_range(0, 3) == 0); k = $urandom_range(0, 255);
            wen = ($urandom_range(0, 3) != 0); wa = $urandom_range(0, 7);
            in_valid = (i < 400) && ($urandom_range(0, 9) < 7);
            ULAControl = 3'(op); ra1 = 3'(a1); ra2 = 3'(a2); select_src = sel;
            constante = 8'(k); wb_en = wen; wb_addr = 3'(wa);
            @(negedge clk);
            exp_ready = !(prev_acc && prev_wen && (a1 == prev_wa || (!sel && a2 == prev_wa)));
            n_cmp++;
            if (in_ready !== exp_ready) begin
                n_fail++; $display("[TB] FAIL rand_ready@%0d: got %b required %b", cyc, in_ready, exp_ready);
            end
            n_cmp++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                last_exp = pk(e);
                if ({res_valid, ULAResult, Flag_z, CarryOut, Overflow, Negative} !== {1'b1, last_exp}) begin
                    n_fail++; $display("[TB] FAIL rand_result@%0d: got %h required %h", cyc,
                                       {res_valid, ULAResult, Flag_z, CarryOut, Overflow, Negative}, {1'b1, last_exp});
                end
            end else if ({res_valid, ULAResult, Flag_z, CarryOut, Overflow, Negative} !== {1'b0, last_exp}) begin
                n_fail++; $display("[TB] FAIL rand_hold@%0d: got %h required %h", cyc,
                                   {res_valid, ULAResult, Flag_z, CarryOut, Overflow, Negative}, {1'b0, last_exp});
            end
            acc = in_valid && (in_ready === 1'b1);
            if (acc) begin
                m = alu_model(op, mdl[a1], sel ? k : mdl[a2]);
                m.cyc = cyc + 2;
                exp_q.push_back(m);
                if (wen) mdl[wa] = m.res;
            end
            prev_acc = acc; prev_wen = wen; prev_wa = wa;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        obs_q.delete();
        for (int r = 0; r < 8; r++) begin
            issue(OP_OR, r, 0, 1'b1, 0, 1'b0, 0, st, ac, ok);
            wait_result(o, okr);
            n_cmp++;
            if (!ok || !okr || o.res !== 8'(mdl[r])) begin
                n_fail++; $display("[TB] FAIL rand_reg_r%0d: got %h required %h", r, o.res, 8'(mdl[r]));
            end
        end
    endtask

    initial begin
        reset = 1'b1; we3 = 1'b0; wa3 = '0; wd3 = '0; in_valid = 1'b0;
        ra1 = '0; ra2 = '0; select_src = 1'b0; constante = '0;
        ULAControl = '0; wb_en = 1'b0; wb_addr = '0;
        $display("[TB] starting datapath_pipe bench");
        test_reset();
        test_load_add_sub();
        test_back_to_back();
        test_forward_wb();
        test_flags();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
